// File: rtl/hwpe_stream_source_job_sequencer.sv
// Job sequencer for one hwpe_stream_source: queues jobs, replays each one REPEAT times.
// Push-to-start 2 cycles; job_ready_o drops while the queue is full, START waits on ready_start.
module hwpe_stream_source_job_sequencer #(
    parameter int unsigned JOB_DEPTH = 4,
    parameter int unsigned TS_W      = 16,
    localparam int unsigned LW       = $clog2(JOB_DEPTH + 1),
    localparam int unsigned PW       = $clog2(JOB_DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            job_valid_i,
    output logic            job_ready_o,
    input  logic [31:0]     job_base_addr_i,
    input  logic [TS_W-1:0] job_trans_size_i,
    input  logic [15:0]     job_line_stride_i,
    input  logic [15:0]     job_line_length_i,
    input  logic [7:0]      job_repeat_i,
    output logic [31:0]     src_base_addr_o,
    output logic [TS_W-1:0] src_trans_size_o,
    output logic [15:0]     src_line_stride_o,
    output logic [15:0]     src_line_length_o,
    output logic            src_req_start_o,
    input  logic            src_ready_start_i,
    input  logic            src_done_i,
    output logic            busy_o,
    output logic            job_done_o,
    output logic            err_size_zero_o,
    output logic [LW-1:0]   queue_level_o,
    output logic [15:0]     jobs_done_cnt_o
);

    typedef struct packed {
        logic [31:0]     base;
        logic [TS_W-1:0] size;
        logic [15:0]     stride;
        logic [15:0]     length;
        logic [7:0]      rep;
    } job_t;

    typedef enum logic [1:0] {IDLE, START, RUN} state_t;

    state_t        state_q, state_d;
    job_t          mem [JOB_DEPTH];
    job_t          head;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [7:0]    rep_cnt_q;
    logic          full, empty, push, pop, run_done, last_run;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(JOB_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full          = (level_q == LW'(JOB_DEPTH));
    assign empty         = (level_q == '0);
    assign job_ready_o   = ~full;
    assign push          = job_valid_i & ~full & ~clear_i;
    assign head          = mem[rd_ptr_q];
    assign last_run      = (rep_cnt_q == 8'd1);
    assign busy_o        = (state_q != IDLE);
    assign queue_level_o = level_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // clear_i overrides every transition and masks req_start in its own cycle
    always_comb begin
        state_d         = state_q;
        pop             = 1'b0;
        run_done        = 1'b0;
        src_req_start_o = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!empty) begin
                        pop = 1'b1;
                        if (head.size != '0) state_d = START;
                    end
                end
                START: begin
                    src_req_start_o = src_ready_start_i;
                    if (src_ready_start_i) state_d = RUN;
                end
                RUN: begin
                    if (src_done_i) begin
                        run_done = 1'b1;
                        state_d  = last_run ? IDLE : START;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= '{base:   job_base_addr_i,   size:   job_trans_size_i,
                                     stride: job_line_stride_i, length: job_line_length_i,
                                     rep:    job_repeat_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            level_q           <= '0;
            rep_cnt_q         <= '0;
            src_base_addr_o   <= '0;
            src_trans_size_o  <= '0;
            src_line_stride_o <= '0;
            src_line_length_o <= '0;
            job_done_o        <= 1'b0;
            err_size_zero_o   <= 1'b0;
            jobs_done_cnt_o   <= '0;
        end else if (clear_i) begin
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            level_q           <= '0;
            rep_cnt_q         <= '0;
            src_base_addr_o   <= '0;
            src_trans_size_o  <= '0;
            src_line_stride_o <= '0;
            src_line_length_o <= '0;
            job_done_o        <= 1'b0;
            err_size_zero_o   <= 1'b0;
            jobs_done_cnt_o   <= '0;
        end else begin
            job_done_o      <= run_done & last_run;
            err_size_zero_o <= pop & (head.size == '0);
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            // a zero-size pop is discarded and leaves the previous ctrl fields in place
            if (pop && (head.size != '0)) begin
                src_base_addr_o   <= head.base;
                src_trans_size_o  <= head.size;
                src_line_stride_o <= head.stride;
                src_line_length_o <= head.length;
                rep_cnt_q         <= (head.rep == 8'd0) ? 8'd1 : head.rep;
            end else if (run_done && !last_run) begin
                rep_cnt_q <= rep_cnt_q - 8'd1;
            end
            if (run_done && last_run) jobs_done_cnt_o <= jobs_done_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_hwpe_stream_source_job_sequencer.sv
// Bench for hwpe_stream_source_job_sequencer: cycle table, directed corner cases, random jobs.
`timescale 1ns/1ps
module tb_hwpe_stream_source_job_sequencer;
    localparam int JOB_DEPTH = 4;
    localparam int TS_W      = 16;
    localparam int LW        = $clog2(JOB_DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst_n, clear, job_valid, job_ready;
    logic [31:0]     job_base;
    logic [TS_W-1:0] job_size;
    logic [15:0]     job_stride, job_len;
    logic [7:0]      job_rep;
    logic [31:0]     src_base;
    logic [TS_W-1:0] src_size;
    logic [15:0]     src_stride, src_len;
    logic            src_req, src_rs, src_done, busy, job_done, err_zero;
    logic [LW-1:0]   level;
    logic [15:0]     cnt;

    hwpe_stream_source_job_sequencer #(.JOB_DEPTH(JOB_DEPTH), .TS_W(TS_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .job_valid_i(job_valid), .job_ready_o(job_ready),
        .job_base_addr_i(job_base), .job_trans_size_i(job_size),
        .job_line_stride_i(job_stride), .job_line_length_i(job_len), .job_repeat_i(job_rep),
        .src_base_addr_o(src_base), .src_trans_size_o(src_size),
        .src_line_stride_o(src_stride), .src_line_length_o(src_len),
        .src_req_start_o(src_req), .src_ready_start_i(src_rs), .src_done_i(src_done),
        .busy_o(busy), .job_done_o(job_done), .err_size_zero_o(err_zero),
        .queue_level_o(level), .jobs_done_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_job(input bit v, input logic [31:0] b, input logic [15:0] s,
                           input logic [15:0] st, input logic [15:0] ln, input logic [7:0] r);
        job_valid = v; job_base = b; job_size = s; job_stride = st; job_len = ln; job_rep = r;
    endtask

    task automatic clear_dut();
        drv(); clear = 1'b1; job_valid = 1'b0; src_done = 1'b0; cyc();
        drv(); clear = 1'b0; cyc();
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (src_req) ok = 1'b1;
            else begin drv(); cyc(); end
        end
    endtask

    typedef struct {
        bit          v;
        logic [31:0] base;
        logic [15:0] size;
        bit          done;
        bit          clr;
        bit          e_req, e_busy, e_jd, e_err;
        int          e_lvl, e_cnt;
        logic [31:0] e_base;
        logic [15:0] e_size;
    } vec_t;

    typedef struct {
        logic [31:0] base;
        logic [15:0] size, stride, len;
        logic [7:0]  rep;
    } job_s;

    vec_t tbl [16];
    job_s jobs [$];
    job_s exp_q [$];
    job_s j, e;

    initial begin
        bit ok, got_req, outst, finished;
        int acc, nreq, idx, jd_seen, err_seen, timer, drain, n_nz, n_zero;
        logic [31:0] base_seen;

        //          v  base          size   dn clr  req busy jd err lvl cnt  e_base        e_size
        tbl[0]  = '{1, 32'h0000_1000, 16'd8, 0, 0,  0,  0,  0,  0,  0,  0,  32'h0,        16'd0};
        tbl[1]  = '{0, 32'h0,         16'd0, 0, 0,  0,  0,  0,  0,  1,  0,  32'h0,        16'd0};
        tbl[2]  = '{0, 32'h0,         16'd0, 0, 0,  1,  1,  0,  0,  0,  0,  32'h0000_1000, 16'd8};
        tbl[3]  = '{0, 32'h0,         16'd0, 1, 0,  0,  1,  0,  0,  0,  0,  32'h0,        16'd0};
        tbl[4]  = '{0, 32'h0,         16'd0, 0, 0,  0,  0,  1,  0,  0,  1,  32'h0,        16'd0};
        tbl[5]  = '{0, 32'h0,         16'd0, 0, 1,  0,  0,  0,  0,  0,  1,  32'h0,        16'd0};
        tbl[6]  = '{1, 32'h0000_2000, 16'd4, 0, 0,  0,  0,  0,  0,  0,  0,  32'h0,        16'd0};
        tbl[7]  = '{1, 32'h0000_2500, 16'd0, 0, 0,  0,  0,  0,  0,  1,  0,  32'h0,        16'd0};
        tbl[8]  = '{1, 32'h0000_3000, 16'd4, 0, 0,  1,  1,  0,  0,  1,  0,  32'h0000_2000, 16'd4};
        tbl[9]  = '{0, 32'h0,         16'd0, 0, 0,  0,  1,  0,  0,  2,  0,  32'h0,        16'd0};
        tbl[10] = '{0, 32'h0,         16'd0, 1, 0,  0,  1,  0,  0,  2,  0,  32'h0,        16'd0};
        tbl[11] = '{0, 32'h0,         16'd0, 0, 0,  0,  0,  1,  0,  2,  1,  32'h0,        16'd0};
        tbl[12] = '{0, 32'h0,         16'd0, 0, 0,  0,  0,  0,  1,  1,  1,  32'h0,        16'd0};
        tbl[13] = '{0, 32'h0,         16'd0, 0, 0,  1,  1,  0,  0,  0,  1,  32'h0000_3000, 16'd4};
        tbl[14] = '{0, 32'h0,         16'd0, 1, 0,  0,  1,  0,  0,  0,  1,  32'h0,        16'd0};
        tbl[15] = '{0, 32'h0,         16'd0, 0, 0,  0,  0,  1,  0,  0,  2,  32'h0,        16'd0};

        rst_n = 1'b0; clear = 1'b0; src_rs = 1'b0; src_done = 1'b0;
        set_job(0, 0, 0, 0, 0, 0);
        repeat (2) cyc();
        chk("rst_ready", job_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_base", src_base, 0);
        drv(); rst_n = 1'b1; cyc();

        // cycle-accurate script: single job, clear, then size 4 / size 0 / size 4
        src_rs = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drv();
            set_job(tbl[i].v, tbl[i].base, tbl[i].size, 16'd0, 16'd0, 8'd0);
            src_done = tbl[i].done;
            clear    = tbl[i].clr;
            cyc();
            chk($sformatf("tbl%0d_req", i), src_req, tbl[i].e_req);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_jobdone", i), job_done, tbl[i].e_jd);
            chk($sformatf("tbl%0d_err", i), err_zero, tbl[i].e_err);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].e_lvl);
            chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].e_cnt);
            if (tbl[i].e_req) begin
                chk($sformatf("tbl%0d_base", i), src_base, tbl[i].e_base);
                chk($sformatf("tbl%0d_size", i), src_size, tbl[i].e_size);
            end
        end
        drv(); set_job(0, 0, 0, 0, 0, 0); src_done = 1'b0; clear = 1'b0; cyc();

        // repeat 3: three starts, fields held, one job_done
        clear_dut();
        src_rs = 1'b1;
        drv(); set_job(1, 32'h4000, 16'd16, 16'd4, 16'd8, 8'd3); cyc();
        drv(); job_valid = 1'b0; cyc();
        for (int r = 0; r < 3; r++) begin
            wait_req(10, ok);
            chk($sformatf("rep_req%0d", r), ok, 1);
            chk($sformatf("rep_base%0d", r), src_base, 32'h4000);
            chk($sformatf("rep_size%0d", r), src_size, 16);
            chk($sformatf("rep_stride%0d", r), src_stride, 4);
            chk($sformatf("rep_len%0d", r), src_len, 8);
            drv(); src_done = 1'b1; cyc();
            drv(); src_done = 1'b0; cyc();
            chk($sformatf("rep_jobdone%0d", r), job_done, (r == 2));
        end
        chk("rep_cnt", cnt, 1);
        nreq = 0;
        repeat (5) begin drv(); cyc(); if (src_req) nreq++; end
        chk("rep_extra_req", nreq, 0);

        // queue full with done withheld
        clear_dut();
        src_rs = 1'b1;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            drv(); set_job(1, 32'h5000 + acc * 32'h100, 16'd4, 16'd0, 16'd0, 8'd1); cyc();
            if (job_valid && job_ready) acc++;
        end
        chk("full_accepted", acc, 5);
        chk("full_ready", job_ready, 0);
        chk("full_level", level, 4);
        chk("full_busy", busy, 1);
        drv(); src_done = 1'b1; cyc();
        if (job_valid && job_ready) acc++;
        got_req = 1'b0; base_seen = '0;
        for (int c = 0; c < 6; c++) begin
            drv(); src_done = 1'b0; job_valid = (acc < 6); cyc();
            if (job_valid && job_ready) acc++;
            if (src_req && !got_req) begin got_req = 1'b1; base_seen = src_base; end
        end
        chk("full_accepted_after_done", acc, 6);
        chk("full_next_req", got_req, 1);
        chk("full_next_base", base_seen, 32'h5100);

        // clear while running with two jobs queued
        clear_dut();
        src_rs = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drv(); set_job(1, 32'h7000 + c, 16'd2, 16'd0, 16'd0, 8'd1); cyc();
        end
        drv(); job_valid = 1'b0; cyc();
        chk("clr_pre_busy", busy, 1);
        chk("clr_pre_level", level, 2);
        drv(); clear = 1'b1; cyc();
        chk("clr_req", src_req, 0);
        drv(); clear = 1'b0; cyc();
        chk("clr_busy", busy, 0);
        chk("clr_level", level, 0);
        chk("clr_ready", job_ready, 1);
        drv(); src_done = 1'b1; cyc();
        drv(); src_done = 1'b0; cyc();
        chk("clr_late_done", job_done, 0);
        chk("clr_cnt", cnt, 0);
        nreq = 0;
        repeat (4) begin drv(); cyc(); if (src_req || busy) nreq++; end
        chk("clr_idle_after", nreq, 0);

        // ready_start withheld, then async reset mid-run
        clear_dut();
        src_rs = 1'b0;
        drv(); set_job(1, 32'h8000, 16'd3, 16'd0, 16'd0, 8'd1); cyc();
        drv(); job_valid = 1'b0; cyc();
        nreq = 0;
        repeat (10) begin drv(); cyc(); if (src_req) nreq++; end
        chk("rs_low_req", nreq, 0);
        chk("rs_low_busy", busy, 1);
        drv(); src_rs = 1'b1; cyc();
        chk("rs_rise_req", src_req, 1);
        chk("rs_rise_base", src_base, 32'h8000);
        drv(); src_rs = 1'b0; cyc();
        chk("rs_run_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_req", src_req, 0);
        chk("arst_base", src_base, 0);
        chk("arst_size", src_size, 0);
        chk("arst_cnt", cnt, 0);
        chk("arst_level", level, 0);
        chk("arst_ready", job_ready, 1);
        drv(); rst_n = 1'b1; cyc();

        // clear in the START cycle suppresses req_start
        src_rs = 1'b0;
        drv(); set_job(1, 32'h9000, 16'd5, 16'd0, 16'd0, 8'd1); cyc();
        drv(); job_valid = 1'b0; cyc();
        drv(); cyc();
        chk("cs_start_busy", busy, 1);
        drv(); src_rs = 1'b1; clear = 1'b1; cyc();
        chk("cs_req", src_req, 0);
        drv(); clear = 1'b0; src_rs = 1'b0; cyc();
        chk("cs_busy", busy, 0);

        // random jobs against an expected list of start requests
        n_nz = 0; n_zero = 0;
        for (int i = 0; i < 40; i++) begin
            j.base   = $urandom;
            j.size   = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            j.stride = 16'($urandom);
            j.len    = 16'($urandom);
            j.rep    = 8'($urandom_range(0, 3));
            jobs.push_back(j);
            if (j.size == 16'd0) n_zero++;
            else begin
                n_nz++;
                for (int r = 0; r < ((j.rep == 0) ? 1 : int'(j.rep)); r++) exp_q.push_back(j);
            end
        end
        clear_dut();
        idx = 0; jd_seen = 0; err_seen = 0; timer = 0; drain = 0;
        outst = 1'b0; finished = 1'b0;
        for (int c = 0; c < 20000 && !finished; c++) begin
            drv();
            if (idx < jobs.size())
                set_job($urandom_range(0, 2) != 0, jobs[idx].base, jobs[idx].size,
                        jobs[idx].stride, jobs[idx].len, jobs[idx].rep);
            else job_valid = 1'b0;
            src_rs   = ($urandom_range(0, 3) != 0);
            src_done = 1'b0;
            if (outst) begin
                timer--;
                if (timer == 0) begin src_done = 1'b1; outst = 1'b0; end
            end else if ($urandom_range(0, 7) == 0) src_done = 1'b1;
            cyc();
            if (job_valid && job_ready) idx++;
            chk("rnd_ready", job_ready, level != LW'(JOB_DEPTH));
            if (src_req) begin
                chk("rnd_req_expected", src_req, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rnd_base", src_base, e.base);
                    chk("rnd_size", src_size, e.size);
                    chk("rnd_stride", src_stride, e.stride);
                    chk("rnd_len", src_len, e.len);
                end
                outst = 1'b1;
                timer = $urandom_range(1, 4);
            end
            if (job_done) jd_seen++;
            if (err_zero) err_seen++;
            if (idx == jobs.size() && exp_q.size() == 0 && !outst) begin
                drain++;
                if (drain >= 8) finished = 1'b1;
            end
        end
        chk("rnd_finished", finished, 1);
        chk("rnd_starts_left", exp_q.size(), 0);
        chk("rnd_jobdone_pulses", jd_seen, n_nz);
        chk("rnd_err_pulses", err_seen, n_zero);
        chk("rnd_cnt", cnt, n_nz);
        chk("rnd_busy_end", busy, 0);
        chk("rnd_level_end", level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
